// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: op-code and state macros, the typed equivalents, and default latencies.
// MDU_MADD_EN adds MADD/MADDU to the set of operations that start a busy period.
`ifndef MDU_CTRL_PKG_SV
`define MDU_CTRL_PKG_SV

`define MDU_NONE    4'd0
`define MDU_MULT    4'd1
`define MDU_MULTU   4'd2
`define MDU_DIV     4'd3
`define MDU_DIVU    4'd4
`define MDU_MFHI    4'd5
`define MDU_MFLO    4'd6
`define MDU_MTHI    4'd7
`define MDU_MTLO    4'd8
`define MDU_MADD    4'd9
`define MDU_MADDU   4'd10

`define MDU_ST_IDLE 1'b0
`define MDU_ST_BUSY 1'b1

package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = `MDU_NONE,
        OP_MULT  = `MDU_MULT,
        OP_MULTU = `MDU_MULTU,
        OP_DIV   = `MDU_DIV,
        OP_DIVU  = `MDU_DIVU,
        OP_MFHI  = `MDU_MFHI,
        OP_MFLO  = `MDU_MFLO,
        OP_MTHI  = `MDU_MTHI,
        OP_MTLO  = `MDU_MTLO,
        OP_MADD  = `MDU_MADD,
        OP_MADDU = `MDU_MADDU
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = `MDU_ST_IDLE,
        ST_BUSY = `MDU_ST_BUSY
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == `MDU_DIV) || (op == `MDU_DIVU);
    endfunction

    // Operations that compute a pending result and hold the unit busy.
    function automatic logic is_long_op(input logic [3:0] op);
        logic long_op;
        long_op = (op == `MDU_MULT) || (op == `MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
        long_op = long_op || (op == `MDU_MADD) || (op == `MDU_MADDU);
`endif
        return long_op;
    endfunction

endpackage

`endif

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces the 64-bit {HI,LO} result and a div-by-zero flag.
// MDU_MADD_EN adds the 64-bit accumulate path for MADD/MADDU.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_quot_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Sign-extended operands keep the low 64 bits of the product exact for signed inputs.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // One unsigned divider on magnitudes; signs restored afterwards (truncate toward zero).
    assign w_signed_div = (i_op == `MDU_DIV);
    assign w_dvd        = (w_signed_div && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_dvs        = (w_signed_div && i_b[31]) ? (32'd0 - i_b) : i_b;
    assign w_quot_mag   = w_dvd / ((w_dvs == 32'd0) ? 32'd1 : w_dvs);
    assign w_rem_mag    = w_dvd % ((w_dvs == 32'd0) ? 32'd1 : w_dvs);
    assign w_quot       = (w_signed_div && (i_a[31] ^ i_b[31])) ? (32'd0 - w_quot_mag) : w_quot_mag;
    assign w_rem        = (w_signed_div && i_a[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_result   = {i_hi, i_lo};
        o_div_zero = 1'b0;
        case (i_op)
            `MDU_MULT:  o_result = w_prod_s;
            `MDU_MULTU: o_result = w_prod_u;
            `MDU_DIV, `MDU_DIVU: begin
                o_div_zero = (i_b == 32'd0);
                if (i_b != 32'd0) o_result = {w_rem, w_quot};
            end
`ifdef MDU_MADD_EN
            `MDU_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
            `MDU_MADDU: o_result = {i_hi, i_lo} + w_prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller: owns HI/LO, holds results back for a fixed latency while busy.
// MDU_MADD_EN enables MADD/MADDU accumulation into HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_MDUA,
    input  logic [31:0] E_MDUB,
    output logic [31:0] E_MDUAns,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [3:0] L_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e  r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [63:0] r_pend, w_pend_nxt;
    logic        r_dz, w_dz_nxt;

    logic [63:0] w_result;
    logic        w_div_zero;

    mdu_arith u_arith (
        .i_op       (E_MDUOp),
        .i_a        (E_MDUA),
        .i_b        (E_MDUB),
        .i_hi       (r_hi),
        .i_lo       (r_lo),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_pend  <= 64'd0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_pend  <= w_pend_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_pend_nxt  = r_pend;
        w_dz_nxt    = r_dz;
        case (r_state)
            ST_IDLE: begin
                if (E_Start) begin
                    if (is_long_op(E_MDUOp)) begin
                        w_pend_nxt  = w_result;
                        w_dz_nxt    = w_div_zero;
                        w_cnt_nxt   = is_div_op(E_MDUOp) ? L_DIV_CNT : L_MULT_CNT;
                        w_state_nxt = ST_BUSY;
                    end else if (E_MDUOp == `MDU_MTHI) begin
                        w_hi_nxt = E_MDUA;
                    end else if (E_MDUOp == `MDU_MTLO) begin
                        w_lo_nxt = E_MDUA;
                    end
                end
            end
            ST_BUSY: begin
                // Starts are ignored here; only the countdown and the final commit happen.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_dz) {w_hi_nxt, w_lo_nxt} = r_pend;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign E_Busy = (r_state == ST_BUSY);
    assign E_HI   = r_hi;
    assign E_LO   = r_lo;

    always_comb begin
        E_MDUAns = 32'd0;
        if (E_MDUOp == `MDU_MFHI) E_MDUAns = r_hi;
        else if (E_MDUOp == `MDU_MFLO) E_MDUAns = r_lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: latency, arithmetic, HI/LO moves, reset abort, back-to-back.
// Expectations for MADDU follow MDU_MADD_EN.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ans;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (op),
        .E_Start  (start),
        .E_MDUA   (a),
        .E_MDUB   (b),
        .E_MDUAns (ans),
        .E_Busy   (busy),
        .E_HI     (hi),
        .E_LO     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the start is sampled by the next posedge and the task returns at the following negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
    endtask

    task automatic busy_len(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        issue(o, va, vb);
        busy_len(cycles);
        check({tag, "_busy"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_ans", ans, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult",  OP_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  OP_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_negdvs", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        issue(OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);

        run_op("div0", OP_DIV, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);

        op = OP_MFHI; #1;
        check("mfhi_ans", ans, 32'h1234);
        op = OP_MFLO; #1;
        check("mflo_ans", ans, 32'h5678);
        op = OP_NONE; #1;
        check("none_ans", ans, 32'd0);
        @(negedge clk);

        // Non-starting codes leave state alone.
        issue(OP_MFHI, 32'hAAAA, 32'd1);
        issue(4'd13, 32'hBBBB, 32'd1);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, 32'h1234);
        check("nop_lo", lo, 32'h5678);

        // Starts while busy are ignored: DIVU 7/2 runs its full latency and commits unchanged.
        issue(OP_DIVU, 32'd7, 32'd2);
        repeat (2) @(negedge clk);
        issue(OP_MULT, 32'd2, 32'd3);
        issue(OP_MTHI, 32'hDEAD, 32'd0);
        check("ign_hi_mid", hi, 32'h1234);
        busy_len(n);
        check("ign_busy_rest", 32'(n), 32'd6);
        check("ign_hi", hi, 32'd1);
        check("ign_lo", lo, 32'd3);

        // Reset during the fourth busy cycle aborts with no later commit.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1; #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        // Back-to-back: second start lands in the first idle cycle after commit.
        issue(OP_MULT, 32'd2, 32'd3);
        busy_len(n);
        check("b2b1_busy", 32'(n), 32'd5);
        check("b2b1_lo", lo, 32'd6);
        issue(OP_MULT, 32'd4, 32'd5);
        check("b2b_gap", {31'd0, busy}, 32'd1);
        busy_len(n);
        check("b2b2_busy", 32'(n), 32'd5);
        check("b2b2_lo", lo, 32'd20);
        check("b2b2_hi", hi, 32'd0);

        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
